// File: rtl/pair_adder_stage_if.sv
// Handshake bundle for pair_adder_stage: operand pair in, {sum, overflow} out.
// The slave modport is the adder stage; the master modport drives it.
interface pair_adder_stage_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] i_term_a;
    logic [WIDTH-1:0] i_term_b;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_overflow;
    logic             o_valid;
    logic             i_ready;

    modport master (
        output i_term_a, i_term_b, i_valid, i_ready,
        input  o_ready, o_sum, o_overflow, o_valid
    );

    modport slave (
        input  i_term_a, i_term_b, i_valid, i_ready,
        output o_ready, o_sum, o_overflow, o_valid
    );
endinterface

// File: rtl/pair_adder_stage.sv
// Two-stage signed pair adder with credit-based flow control and an output FWFT FIFO.
// Define PAIR_ADDER_SATURATE_EN to clamp o_sum on overflow instead of wrapping.
module pair_adder_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input logic            i_clock,
    input logic            i_reset,
    pair_adder_stage_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(DEPTH + 3);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             ovf;
    } entry_t;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             v0_q, v0_d;
    entry_t           s1_q, s1_d;
    logic             v1_q, v1_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    entry_t           last_q, last_d;

    logic [WIDTH:0]   full;
    logic             ovf;
    logic [WIDTH-1:0] res;
    logic [OW-1:0]    occ;
    logic             accept;
    logic             pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Every in-flight pair already owns a FIFO slot, so nothing ever stalls.
    assign occ         = OW'(cnt_q) + OW'(v0_q) + OW'(v1_q);
    assign bus.o_ready = (occ < OW'(DEPTH)) && !i_reset;
    assign accept      = bus.i_valid && bus.o_ready;
    assign bus.o_valid = (cnt_q != '0);
    assign pop         = bus.o_valid && bus.i_ready;

    // Head shows the FIFO front; the last popped entry is held while empty.
    assign bus.o_sum      = bus.o_valid ? mem_q[rd_q].sum : last_q.sum;
    assign bus.o_overflow = bus.o_valid ? mem_q[rd_q].ovf : last_q.ovf;

    // Sign-extended add of the S0 operands, overflow and optional clamp.
    always_comb begin
        full = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
        ovf  = full[WIDTH] ^ full[WIDTH-1];
`ifdef PAIR_ADDER_SATURATE_EN
        if (ovf)
            res = full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
        else
            res = full[WIDTH-1:0];
`else
        res = full[WIDTH-1:0];
`endif
    end

    // Next state of the S0 operand and S1 result registers.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        v0_d = accept;
        if (accept) begin
            a_d = bus.i_term_a;
            b_d = bus.i_term_b;
        end
        s1_d = s1_q;
        v1_d = v0_q;
        if (v0_q) begin
            s1_d.sum = res;
            s1_d.ovf = ovf;
        end
    end

    // FIFO write of the S1 result, pop of the head, and occupancy count.
    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (v1_q) begin
            mem_d[wr_q] = s1_q;
            wr_d        = wrap_inc(wr_q);
        end
        if (pop) begin
            last_d = mem_q[rd_q];
            rd_d   = wrap_inc(rd_q);
        end
        case ({v1_q, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control and datapath registers; reset drops everything in flight.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            a_q    <= '0;
            b_q    <= '0;
            v0_q   <= 1'b0;
            s1_q   <= '0;
            v1_q   <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            v0_q   <= v0_d;
            s1_q   <= s1_d;
            v1_q   <= v1_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    // FIFO storage needs no reset: it is only visible when count is nonzero.
    always_ff @(posedge i_clock) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_pair_adder_stage.sv
// Directed bench for pair_adder_stage (WIDTH=16, DEPTH=4).
// Vector table plus reset, backpressure, streaming and mid-flight reset sequences.
module tb_pair_adder_stage;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;

    pair_adder_stage_if #(.WIDTH(W)) bus();

    pair_adder_stage #(.WIDTH(W), .DEPTH(4)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] sum;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        ovf;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;
    bit   rand_rdy = 1'b0;
    res_t exp_q[$];

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
        int   s;
        res_t r;
        s     = int'($signed(a)) + int'($signed(b));
        r.ovf = (s > 32767) || (s < -32768);
        r.sum = 16'(s);
`ifdef PAIR_ADDER_SATURATE_EN
        if (s > 32767) r.sum = 16'h7fff;
        else if (s < -32768) r.sum = 16'h8000;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: accepted pairs queued through the model, pops checked in order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.o_valid && bus.i_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got sum 0x%0h, nothing expected", bus.o_sum);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("out_sum", 32'(bus.o_sum), 32'(e.sum));
                    check("out_ovf", 32'(bus.o_overflow), 32'(e.ovf));
                end
            end
            if (bus.i_valid && bus.o_ready)
                exp_q.push_back(model(bus.i_term_a, bus.i_term_b));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.i_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int t;
        t = 0;
        bus.i_term_a = a;
        bus.i_term_b = b;
        bus.i_valid  = 1'b1;
        while (!bus.o_ready && t < 50) begin
            step();
            t++;
        end
        if (!bus.o_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: o_ready stayed 0 for %0d cycles, required 1", t);
        end
        step();
    endtask

    task automatic drain(input int n_exp, input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            step();
            t++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_count"}, 32'(pops), 32'(n_exp));
    endtask

    task automatic single_pair(input vec_t v, input string name);
        int n;
        pops = 0;
        bus.i_ready = 1'b1;
        check({name, "_ready"}, 32'(bus.o_ready), 32'd1);
        bus.i_term_a = v.a;
        bus.i_term_b = v.b;
        bus.i_valid  = 1'b1;
        step();
        bus.i_valid = 1'b0;
        n = 1;
        while (!bus.o_valid && n < 10) begin
            step();
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'd3);
        check({name, "_sum"}, 32'(bus.o_sum), 32'(v.sum));
        check({name, "_ovf"}, 32'(bus.o_overflow), 32'(v.ovf));
        step();
        check({name, "_one_cycle"}, 32'(bus.o_valid), 32'd0);
        check({name, "_hold_sum"}, 32'(bus.o_sum), 32'(v.sum));
        check({name, "_pops"}, 32'(pops), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   k;
        int   acc;

        vecs[0] = '{16'h0003, 16'h0005, 16'h0008, 1'b0};
`ifdef PAIR_ADDER_SATURATE_EN
        vecs[1] = '{16'h7fff, 16'h0001, 16'h7fff, 1'b1};
        vecs[2] = '{16'h8000, 16'hffff, 16'h8000, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 16'h8000, 1'b1};
`else
        vecs[1] = '{16'h7fff, 16'h0001, 16'h8000, 1'b1};
        vecs[2] = '{16'h8000, 16'hffff, 16'h7fff, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
`endif
        vecs[3] = '{16'hffff, 16'hffff, 16'hfffe, 1'b0};
        vecs[5] = '{16'h1234, 16'h4321, 16'h5555, 1'b0};

        rst          = 1'b1;
        bus.i_valid  = 1'b1;
        bus.i_term_a = 16'h1111;
        bus.i_term_b = 16'h2222;
        bus.i_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_ready", 32'(bus.o_ready), 32'd0);
            check("reset_valid", 32'(bus.o_valid), 32'd0);
            check("reset_sum", 32'(bus.o_sum), 32'd0);
            check("reset_ovf", 32'(bus.o_overflow), 32'd0);
        end
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        check("ready_after_reset", 32'(bus.o_ready), 32'd1);
        step();

        for (int i = 0; i < 6; i++)
            single_pair(vecs[i], $sformatf("vec%0d", i));

        pops = 0;
        bus.i_ready = 1'b0;
        k   = 1;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            bus.i_term_a = 16'(k);
            bus.i_term_b = 16'(2 * k);
            bus.i_valid  = 1'b1;
            if (bus.o_ready) begin
                acc++;
                step();
                k++;
            end else begin
                step();
            end
        end
        check("bp_accepted", 32'(acc), 32'd4);
        check("bp_ready_low", 32'(bus.o_ready), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check("bp_ready_still_low", 32'(bus.o_ready), 32'd0);
        check("bp_head_valid", 32'(bus.o_valid), 32'd1);
        check("bp_head_sum", 32'(bus.o_sum), 32'd3);
        bus.i_ready = 1'b1;
        send(16'd5, 16'd10);
        send(16'd6, 16'd12);
        bus.i_valid = 1'b0;
        drain(6, "bp");

        pops = 0;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) check("stream_ready", 32'(bus.o_ready), 32'd1);
            send(16'($urandom), 16'($urandom));
        end
        bus.i_valid = 1'b0;
        drain(100, "stream");

        pops = 0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++)
            send(16'($urandom), 16'($urandom));
        bus.i_valid = 1'b0;
        drain(100, "rand");
        rand_rdy = 1'b0;
        bus.i_ready = 1'b1;
        step();

        pops = 0;
        send(16'h0010, 16'h0020);
        bus.i_term_a = 16'h0030;
        bus.i_term_b = 16'h0040;
        step();
        bus.i_term_a = 16'h0050;
        bus.i_term_b = 16'h0060;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("midrst_no_valid", 32'(bus.o_valid), 32'd0);
            step();
        end
        check("midrst_pops", 32'(pops), 32'd0);
        single_pair('{16'h0100, 16'h0200, 16'h0300, 1'b0}, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
